// File: rtl/proc_barrier_xbar_if.sv
// Bundle of engine status, trigger configuration and barrier/interrupt outputs
// exchanged between the hash-build processors and proc_barrier_xbar.
interface proc_barrier_xbar_if #(
    parameter int NUM_PROC = 3,
    parameter int STATE_W  = 3,
    parameter int INDEX_W  = 7,
    parameter int CNT_W    = 4
);
    localparam int ACT_W = $clog2(NUM_PROC) + 1;

    logic [NUM_PROC*STATE_W-1:0] norm_state;
    logic [NUM_PROC*INDEX_W-1:0] norm_index;
    logic [NUM_PROC*STATE_W-1:0] clam_state;
    logic [NUM_PROC*INDEX_W-1:0] clam_index;
    logic [NUM_PROC-1:0]         norm_waiting;
    logic [NUM_PROC-1:0]         clam_waiting;
    logic [NUM_PROC-1:0]         cfg_norm_trig_en;
    logic [STATE_W-1:0]          cfg_norm_trig_state;
    logic [NUM_PROC*INDEX_W-1:0] cfg_norm_trig_index;
    logic [NUM_PROC-1:0]         cfg_clam_trig_en;
    logic [STATE_W-1:0]          cfg_clam_trig_state;
    logic [NUM_PROC*INDEX_W-1:0] cfg_clam_trig_index;
    logic [NUM_PROC-1:0]         cont;
    logic [NUM_PROC-1:0]         norm_interrupt;
    logic [NUM_PROC-1:0]         clam_interrupt;
    logic [NUM_PROC-1:0]         norm_transfered;
    logic [NUM_PROC-1:0]         clam_transfered;
    logic [ACT_W-1:0]            active_cnt;
    logic [CNT_W-1:0]            release_cnt;
    logic                        busy;

    modport master (
        output norm_state, norm_index, clam_state, clam_index,
               norm_waiting, clam_waiting,
               cfg_norm_trig_en, cfg_norm_trig_state, cfg_norm_trig_index,
               cfg_clam_trig_en, cfg_clam_trig_state, cfg_clam_trig_index,
        input  cont, norm_interrupt, clam_interrupt,
               norm_transfered, clam_transfered,
               active_cnt, release_cnt, busy
    );

    modport slave (
        input  norm_state, norm_index, clam_state, clam_index,
               norm_waiting, clam_waiting,
               cfg_norm_trig_en, cfg_norm_trig_state, cfg_norm_trig_index,
               cfg_clam_trig_en, cfg_clam_trig_state, cfg_clam_trig_index,
        output cont, norm_interrupt, clam_interrupt,
               norm_transfered, clam_transfered,
               active_cnt, release_cnt, busy
    );
endinterface

// File: rtl/proc_barrier_xbar.sv
// Staged barrier release (participating set grows by one per release) plus
// per-processor Norm/Clam hand-off interrupts and sticky transfer flags.
module proc_barrier_xbar #(
    parameter int NUM_PROC     = 3,
    parameter int STATE_W      = 3,
    parameter int INDEX_W      = 7,
    parameter int START_ACTIVE = 1,
    parameter int CNT_W        = 4
) (
    input logic               clk,
    input logic               rst,
    proc_barrier_xbar_if.slave bus
);
    localparam int ACT_W = $clog2(NUM_PROC) + 1;

    typedef enum logic [1:0] {IDLE, RELEASE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [NUM_PROC-1:0] cont_q, cont_d;
    logic [NUM_PROC-1:0] m_old_q, m_old_d;
    logic [NUM_PROC-1:0] mask;
    logic [ACT_W-1:0]    active_cnt_q, active_cnt_d;
    logic [CNT_W-1:0]    release_cnt_q, release_cnt_d;
    logic                busy_q, busy_d;
    logic [NUM_PROC-1:0] norm_int_q, norm_int_d, clam_int_q, clam_int_d;
    logic [NUM_PROC-1:0] norm_xfer_q, norm_xfer_d, clam_xfer_q, clam_xfer_d;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_PROC; i++)
            mask[i] = (ACT_W'(i) < active_cnt_q);
    end

    // Outputs are computed one cycle ahead so cont/busy leave straight from flops.
    always_comb begin
        state_d       = state_q;
        cont_d        = '0;
        busy_d        = busy_q;
        m_old_d       = m_old_q;
        active_cnt_d  = active_cnt_q;
        release_cnt_d = release_cnt_q;
        case (state_q)
            IDLE: begin
                if ((bus.norm_waiting & bus.clam_waiting & mask) == mask) begin
                    state_d = RELEASE;
                    cont_d  = mask;
                    busy_d  = 1'b1;
                    m_old_d = mask;
                end
            end
            RELEASE: begin
                state_d = DRAIN;
                if (active_cnt_q != ACT_W'(NUM_PROC))
                    active_cnt_d = active_cnt_q + 1'b1;
                if (release_cnt_q != '1)
                    release_cnt_d = release_cnt_q + 1'b1;
            end
            DRAIN: begin
                if (((bus.norm_waiting | bus.clam_waiting) & m_old_q) == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The last processor has no successor, so its interrupt and bit 0 of transfered stay low.
    always_comb begin
        norm_int_d  = '0;
        clam_int_d  = '0;
        norm_xfer_d = '0;
        clam_xfer_d = '0;
        for (int p = 0; p < NUM_PROC - 1; p++) begin
            norm_int_d[p] = (bus.cfg_norm_trig_en[p]
                             && bus.norm_state[p*STATE_W +: STATE_W] == bus.cfg_norm_trig_state
                             && bus.norm_index[p*INDEX_W +: INDEX_W] == bus.cfg_norm_trig_index[p*INDEX_W +: INDEX_W])
                            || (norm_int_q[p] && !bus.norm_waiting[p]);
            clam_int_d[p] = (bus.cfg_clam_trig_en[p]
                             && bus.clam_state[p*STATE_W +: STATE_W] == bus.cfg_clam_trig_state
                             && bus.clam_index[p*INDEX_W +: INDEX_W] == bus.cfg_clam_trig_index[p*INDEX_W +: INDEX_W])
                            || (clam_int_q[p] && !bus.clam_waiting[p]);
            norm_xfer_d[p+1] = norm_xfer_q[p+1] | norm_int_q[p];
            clam_xfer_d[p+1] = clam_xfer_q[p+1] | clam_int_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cont_q        <= '0;
            busy_q        <= 1'b0;
            m_old_q       <= '0;
            active_cnt_q  <= ACT_W'(START_ACTIVE);
            release_cnt_q <= '0;
            norm_int_q    <= '0;
            clam_int_q    <= '0;
            norm_xfer_q   <= '0;
            clam_xfer_q   <= '0;
        end else begin
            state_q       <= state_d;
            cont_q        <= cont_d;
            busy_q        <= busy_d;
            m_old_q       <= m_old_d;
            active_cnt_q  <= active_cnt_d;
            release_cnt_q <= release_cnt_d;
            norm_int_q    <= norm_int_d;
            clam_int_q    <= clam_int_d;
            norm_xfer_q   <= norm_xfer_d;
            clam_xfer_q   <= clam_xfer_d;
        end
    end

    assign bus.cont            = cont_q;
    assign bus.busy            = busy_q;
    assign bus.active_cnt      = active_cnt_q;
    assign bus.release_cnt     = release_cnt_q;
    assign bus.norm_interrupt  = norm_int_q;
    assign bus.clam_interrupt  = clam_int_q;
    assign bus.norm_transfered = norm_xfer_q;
    assign bus.clam_transfered = clam_xfer_q;
endmodule

// File: tb/tb_proc_barrier_xbar.sv
// Directed plus randomized bench for proc_barrier_xbar against a cycle-level
// behavioural model built from masks, integer counters and a release phase.
module tb_proc_barrier_xbar;
    localparam int NP = 3;
    localparam int SW = 3;
    localparam int IW = 7;
    localparam int SA = 1;
    localparam int CW = 4;
    localparam int REL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_barrier_xbar_if #(.NUM_PROC(NP), .STATE_W(SW), .INDEX_W(IW), .CNT_W(CW)) bus ();

    proc_barrier_xbar #(
        .NUM_PROC(NP), .STATE_W(SW), .INDEX_W(IW), .START_ACTIVE(SA), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: participating count, releases done, and where we are in a release
    // (0 = waiting for barrier, 1 = pulse just issued, 2 = waiting for engines to leave).
    int          m_active;
    int          m_release;
    int          m_phase;
    logic [NP-1:0] m_mold;
    logic [NP-1:0] e_cont, e_nint, e_cint, e_nx, e_cx;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("cont", 32'(bus.cont), 32'(e_cont));
        checkOne("active_cnt", 32'(bus.active_cnt), 32'(m_active));
        checkOne("release_cnt", 32'(bus.release_cnt), 32'(m_release));
        checkOne("busy", 32'(bus.busy), 32'(m_phase != 0));
        checkOne("norm_interrupt", 32'(bus.norm_interrupt), 32'(e_nint));
        checkOne("clam_interrupt", 32'(bus.clam_interrupt), 32'(e_cint));
        checkOne("norm_transfered", 32'(bus.norm_transfered), 32'(e_nx));
        checkOne("clam_transfered", 32'(bus.clam_transfered), 32'(e_cx));
    endtask

    task automatic modelStep();
        logic [NP-1:0] mask;
        logic [NP-1:0] nw, cw;
        bit nhit, chit;
        if (rst) begin
            m_active = SA; m_release = 0; m_phase = 0; m_mold = '0;
            e_cont = '0; e_nint = '0; e_cint = '0; e_nx = '0; e_cx = '0;
            return;
        end
        mask = NP'((1 << m_active) - 1);
        nw = bus.norm_waiting;
        cw = bus.clam_waiting;
        e_cont = '0;
        if (m_phase == 0) begin
            if ((nw & cw & mask) == mask) begin
                e_cont = mask; m_mold = mask; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_active  = (m_active < NP) ? m_active + 1 : NP;
            m_release = (m_release < REL_MAX) ? m_release + 1 : REL_MAX;
            m_phase   = 2;
        end else begin
            if (((nw | cw) & m_mold) == '0) m_phase = 0;
        end
        for (int p = 0; p < NP - 1; p++) begin
            nhit = bus.cfg_norm_trig_en[p]
                   && bus.norm_state[p*SW +: SW] == bus.cfg_norm_trig_state
                   && bus.norm_index[p*IW +: IW] == bus.cfg_norm_trig_index[p*IW +: IW];
            chit = bus.cfg_clam_trig_en[p]
                   && bus.clam_state[p*SW +: SW] == bus.cfg_clam_trig_state
                   && bus.clam_index[p*IW +: IW] == bus.cfg_clam_trig_index[p*IW +: IW];
            if (e_nint[p]) e_nx[p+1] = 1'b1;
            if (e_cint[p]) e_cx[p+1] = 1'b1;
            e_nint[p] = nhit ? 1'b1 : (nw[p] ? 1'b0 : e_nint[p]);
            e_cint[p] = chit ? 1'b1 : (cw[p] ? 1'b0 : e_cint[p]);
        end
    endtask

    // Inputs are held for one full cycle; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic setWait(input logic [NP-1:0] nw, input logic [NP-1:0] cw);
        bus.norm_waiting = nw;
        bus.clam_waiting = cw;
    endtask

    initial begin
        rst = 1'b1;
        bus.norm_state = '0; bus.norm_index = '0;
        bus.clam_state = '0; bus.clam_index = '0;
        setWait('0, '0);
        bus.cfg_norm_trig_en = '0; bus.cfg_norm_trig_state = '0; bus.cfg_norm_trig_index = '0;
        bus.cfg_clam_trig_en = '0; bus.cfg_clam_trig_state = '0; bus.cfg_clam_trig_index = '0;
        applyStimulus();
        applyStimulus();
        checkOne("reset_active", 32'(bus.active_cnt), SA);
        rst = 1'b0;
        repeat (7) applyStimulus();

        // First release with only processor 0 participating.
        setWait(3'b001, 3'b001);
        applyStimulus();
        checkOne("rel1_cont", 32'(bus.cont), 32'b001);
        applyStimulus();
        checkOne("rel1_active", 32'(bus.active_cnt), 2);
        checkOne("rel1_release", 32'(bus.release_cnt), 1);
        applyStimulus();
        setWait('0, '0);
        applyStimulus();
        checkOne("rel1_busy_drop", 32'(bus.busy), 0);

        setWait(3'b011, 3'b011);
        applyStimulus();
        checkOne("rel2_cont", 32'(bus.cont), 32'b011);
        applyStimulus();
        setWait('0, '0);
        applyStimulus();

        setWait(3'b111, 3'b111);
        applyStimulus();
        checkOne("rel3_cont", 32'(bus.cont), 32'b111);
        applyStimulus();
        checkOne("rel3_active_sat", 32'(bus.active_cnt), 3);
        setWait('0, '0);
        applyStimulus();

        // Clam side incomplete: no release until clam_waiting[1] rises.
        setWait(3'b111, 3'b101);
        repeat (3) applyStimulus();
        checkOne("partial_no_cont", 32'(bus.cont), 0);
        setWait(3'b111, 3'b111);
        applyStimulus();
        checkOne("partial_cont", 32'(bus.cont), 32'b111);
        applyStimulus();
        setWait('0, '0);
        applyStimulus();

        // Norm hand-off trigger on processor 0.
        bus.cfg_norm_trig_en = 3'b001;
        bus.cfg_norm_trig_state = 3'd6;
        bus.cfg_norm_trig_index[0 +: IW] = 7'd3;
        bus.norm_state[0 +: SW] = 3'd6;
        bus.norm_index[0 +: IW] = 7'd3;
        applyStimulus();
        checkOne("nint0_set", 32'(bus.norm_interrupt), 32'b001);
        bus.norm_state[0 +: SW] = 3'd0;
        applyStimulus();
        checkOne("nx1_set", 32'(bus.norm_transfered), 32'b010);
        setWait(3'b001, 3'b000);
        applyStimulus();
        checkOne("nint0_clear", 32'(bus.norm_interrupt), 0);
        checkOne("nx1_sticky", 32'(bus.norm_transfered), 32'b010);
        bus.norm_state[0 +: SW] = 3'd6;
        applyStimulus();
        checkOne("nint0_set_wins", 32'(bus.norm_interrupt), 32'b001);
        bus.cfg_norm_trig_en = 3'b100;
        bus.cfg_norm_trig_index[2*IW +: IW] = 7'd5;
        bus.norm_state[2*SW +: SW] = 3'd6;
        bus.norm_index[2*IW +: IW] = 7'd5;
        applyStimulus();
        checkOne("nint2_tied", 32'(bus.norm_interrupt[2]), 0);
        setWait('0, '0);
        bus.cfg_norm_trig_en = '0;
        applyStimulus();

        // Saturate the release counter.
        repeat (20) begin
            setWait(3'b111, 3'b111);
            applyStimulus();
            applyStimulus();
            setWait('0, '0);
            applyStimulus();
        end
        checkOne("release_sat", 32'(bus.release_cnt), REL_MAX);

        // Reset while draining.
        setWait(3'b111, 3'b111);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOne("rst_drain_active", 32'(bus.active_cnt), SA);
        checkOne("rst_drain_busy", 32'(bus.busy), 0);
        checkOne("rst_drain_xfer", 32'(bus.norm_transfered), 0);
        rst = 1'b0;
        applyStimulus();
        checkOne("post_rst_cont", 32'(bus.cont), 32'b001);
        setWait('0, '0);
        applyStimulus();
        applyStimulus();

        // Randomized traffic with trigger matches made likely.
        repeat (400) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.norm_waiting = ($urandom_range(0, 2) == 0) ? '1 : NP'($urandom);
            bus.clam_waiting = ($urandom_range(0, 2) == 0) ? '1 : NP'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                bus.cfg_norm_trig_en    = NP'($urandom);
                bus.cfg_clam_trig_en    = NP'($urandom);
                bus.cfg_norm_trig_state = SW'($urandom);
                bus.cfg_clam_trig_state = SW'($urandom);
                bus.cfg_norm_trig_index = (NP*IW)'({$urandom, $urandom});
                bus.cfg_clam_trig_index = (NP*IW)'({$urandom, $urandom});
            end
            for (int p = 0; p < NP; p++) begin
                bus.norm_state[p*SW +: SW] = $urandom_range(0, 1) ? bus.cfg_norm_trig_state : SW'($urandom);
                bus.norm_index[p*IW +: IW] = $urandom_range(0, 1) ? bus.cfg_norm_trig_index[p*IW +: IW] : IW'($urandom);
                bus.clam_state[p*SW +: SW] = $urandom_range(0, 1) ? bus.cfg_clam_trig_state : SW'($urandom);
                bus.clam_index[p*IW +: IW] = $urandom_range(0, 1) ? bus.cfg_clam_trig_index[p*IW +: IW] : IW'($urandom);
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_barrier_xbar.md
Name: proc_barrier_xbar

Overview:
- Parametrised successor to the 3-processor continue/interrupt crossbar.
- Coordinates NUM_PROC hash-build processors, each with a Norm and a Clam engine.
- Generates staged barrier releases (cont): the participating set grows by one processor per release.
- Raises per-processor hand-off interrupts when a run-time-programmed state/index trigger is hit, and records the downstream "transfered" flags.

Parameters:
- NUM_PROC, 3, number of processors (2..16).
- STATE_W, 3, width of each engine state field.
- INDEX_W, 7, width of each engine index field.
- START_ACTIVE, 1, processors participating in the first release (1..NUM_PROC).
- CNT_W, 4, width of the release counter (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- norm_state  in  NUM_PROC*STATE_W  Norm engine state, processor p at bits [p*STATE_W +: STATE_W]
- norm_index  in  NUM_PROC*INDEX_W  Norm engine array index, same packing
- clam_state  in  NUM_PROC*STATE_W  Clam engine state
- clam_index  in  NUM_PROC*INDEX_W  Clam engine index
- norm_waiting  in  NUM_PROC  Norm engine p parked, waiting for cont/interrupt service
- clam_waiting  in  NUM_PROC  Clam engine p parked
- cfg_norm_trig_en  in  NUM_PROC  enable Norm hand-off trigger for p
- cfg_norm_trig_state  in  STATE_W  Norm trigger state (shared by all p)
- cfg_norm_trig_index  in  NUM_PROC*INDEX_W  Norm trigger index, per p
- cfg_clam_trig_en  in  NUM_PROC  enable Clam hand-off trigger for p
- cfg_clam_trig_state  in  STATE_W  Clam trigger state (shared by all p)
- cfg_clam_trig_index  in  NUM_PROC*INDEX_W  Clam trigger index, per p
- cont  out  NUM_PROC  one-cycle continue pulse per processor
- norm_interrupt  out  NUM_PROC  sticky Norm hand-off interrupt
- clam_interrupt  out  NUM_PROC  sticky Clam hand-off interrupt
- norm_transfered  out  NUM_PROC  sticky: Norm work handed to p
- clam_transfered  out  NUM_PROC  sticky: Clam work handed to p
- active_cnt  out  log2(NUM_PROC)+1  number of currently participating processors
- release_cnt  out  CNT_W  number of completed releases, saturating
- busy  out  1  high while FSM is in RELEASE or DRAIN

Behaviour:
- Reset values: all outputs 0; active_cnt=START_ACTIVE; FSM=IDLE. All outputs are registered.
- Participating mask M: bits 0..active_cnt-1 set.
- FSM:
  - IDLE: if (norm_waiting & clam_waiting & M)==M, go to RELEASE.
  - RELEASE: lasts exactly 1 cycle, with cont=M (all other bits 0). On exit, active_cnt increments, saturating at NUM_PROC. release_cnt increments, saturating at 2^CNT_W-1. Go to DRAIN.
  - DRAIN: hold cont=0. When ((norm_waiting | clam_waiting) & M_old)==0, go to IDLE. M_old is the mask used for the release just issued.
- Latency: waiting condition met in cycle N → cont high in cycle N+1 → busy high in N+1 until DRAIN exit.
- After release_cnt saturates, releases continue; only the counter holds.
- Waiting bits outside M are ignored for the release decision.
- Interrupts, for p in 0..NUM_PROC-2; bit NUM_PROC-1 is tied 0 because p has no successor:
  - Norm set condition: cfg_norm_trig_en[p], norm_state[p]==cfg_norm_trig_state and norm_index[p]==cfg_norm_trig_index[p]. norm_interrupt[p] is set the next cycle.
  - Norm clear: when norm_waiting[p]=1.
  - Set and clear in the same cycle: set wins.
  - Clam interrupts follow the same rules with clam_* signals.
- Transfered flags:
  - norm_transfered[p+1] is set in the cycle after norm_interrupt[p] is first observed high. It stays set until rst.
  - norm_transfered[0] is always 0.
  - clam_transfered follows the same rules.
- Interrupt/transfer logic is independent of the barrier FSM and works in every FSM state.
- cfg_* inputs are sampled every cycle; changing them mid-run affects only future matches.
- rst asserted mid-operation (any state): next cycle all outputs are at reset values and FSM=IDLE. No partial cont pulse is emitted.

Test Plan:
- NUM_PROC=3, START_ACTIVE=1, raise norm_waiting=3'b001, clam_waiting=3'b001 at cycle 10 → cont=3'b001 for exactly cycle 11. active_cnt becomes 2; release_cnt=1; busy=1 until both waiting bits drop.
- Continue from the previous case: waiting=3'b011 on both engines → cont=3'b011 single pulse; active_cnt=3. A third release with waiting=3'b111 → cont=3'b111; active_cnt stays 3.
- norm_waiting=3'b111, clam_waiting=3'b101 with active_cnt=3 → no cont. Raising clam_waiting[1] → cont=3'b111 one cycle later.
- cfg_norm_trig_en=3'b001, state=6, index[0]=3; drive norm_state0=6, norm_index0=3 → norm_interrupt[0]=1 next cycle and norm_transfered[1]=1 a cycle later. norm_waiting[0]=1 with no match → interrupt clears; transfered stays 1.
- Trigger match and norm_waiting[0] in the same cycle → norm_interrupt[0] stays/becomes 1. Trigger with p=2 enabled → norm_interrupt[2] stays 0.
- Force 20 releases with CNT_W=4 → release_cnt saturates at 15. Assert rst during DRAIN → all outputs 0, active_cnt=START_ACTIVE, and a new release proceeds from IDLE.
